// File: rtl/exdecomp_ctrl.sv
// Flow-control sequencer around the fixed-latency exbus decompressor: reserves an
// output FIFO slot per issued word and drains/resets the decompressor on request.
module exdecomp_ctrl #(
  parameter int unsigned LGFIFO = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [34:0] s_word,
  input  logic        i_resync,
  output logic        d_stb,
  output logic [34:0] d_word,
  output logic        d_reset,
  input  logic        r_stb,
  input  logic [34:0] r_word,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [34:0] m_word,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned DEPTH = 1 << LGFIFO;

  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_DRAIN} state_t;

  state_t            state_q;
  logic              d_reset_q, busy_q;
  logic [LGFIFO:0]   reserved_q, reserved_d;
  logic [LGFIFO:0]   count_q, count_d;
  logic [2:0]        inflight_q, inflight_d;
  logic [LGFIFO-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [34:0]       mem [DEPTH];
  logic              d_stb_q, err_q;
  logic [34:0]       d_word_q, m_word_q, head_d;
  logic              accept, pop, full, drop, wr_en;

  always_comb begin
    s_ready    = (state_q == ST_RUN) && (reserved_q < (LGFIFO+1)'(DEPTH));
    accept     = s_valid && s_ready;
    m_valid    = (count_q != '0);
    pop        = m_valid && m_ready;
    full       = (count_q == (LGFIFO+1)'(DEPTH));
    drop       = r_stb && ((full && !pop) || (inflight_q == '0));
    wr_en      = r_stb && !drop;
    reserved_d = reserved_q + (LGFIFO+1)'(accept) - (LGFIFO+1)'(pop);
    inflight_d = inflight_q + 3'(accept) - 3'(r_stb && (inflight_q != '0));
    count_d    = count_q + (LGFIFO+1)'(wr_en) - (LGFIFO+1)'(pop);
    rd_ptr_d   = rd_ptr_q + LGFIFO'(pop);
    // A write landing on the next read slot means the FIFO was (or becomes) empty: bypass it.
    head_d     = (wr_en && (wr_ptr_q == rd_ptr_d)) ? r_word : mem[rd_ptr_d];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_RST;
      d_reset_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_RST: begin
          state_q   <= ST_RUN;
          d_reset_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        ST_RUN: begin
          if (i_resync) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Leave only once the last outstanding result has been absorbed this cycle.
          if (inflight_d == '0) begin
            state_q   <= ST_RST;
            d_reset_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_RST;
          d_reset_q <= 1'b1;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      reserved_q <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      d_stb_q    <= 1'b0;
      d_word_q   <= '0;
      m_word_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_q + LGFIFO'(wr_en);
      rd_ptr_q   <= rd_ptr_d;
      d_stb_q    <= accept;
      if (accept)
        d_word_q <= s_word;
      if (count_d != '0)
        m_word_q <= head_d;
      if (drop)
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr_q] <= r_word;
  end

  assign d_stb   = d_stb_q;
  assign d_word  = d_word_q;
  assign d_reset = d_reset_q;
  assign m_word  = m_word_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule
